pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded by reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0100, exception/trap entry address.
REQ-004 Parameter INC, default 4, sequential increment; power of two, ≥ 2.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2–16.
REQ-006 Reset is asynchronous and active-high; one clock.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 stall  input  1  hold PC and RAS.
REQ-010 flush_valid  input  1  redirect from EX (branch mispredict or jump).
REQ-011 flush_target  input  XLEN  redirect address.
REQ-012 exc_valid  input  1  exception request.
REQ-013 call  input  1  instruction at current_pc is a call; push current_pc+INC.
REQ-014 ret  input  1  instruction at current_pc is a return; predict from RAS top.
REQ-015 current_pc  output  XLEN  registered fetch PC.
REQ-016 misalign_err  output  1  registered one-cycle pulse for a misaligned flush_target.
REQ-017 ras_count  output  $clog2(RAS_DEPTH)+1  number of valid RAS entries.

Function
REQ-018 Next-PC priority, highest first: exc_valid > flush_valid > stall > ret (RAS non-empty) > sequential.
REQ-019 exc_valid=1 -> current_pc <= EXC_VEC; RAS cleared (ras_count <= 0); other inputs ignored.
REQ-020 flush_valid=1, exc_valid=0, flush_target aligned (low log2(INC) bits zero) -> current_pc <= flush_target, regardless of stall.
REQ-021 flush_valid=1, exc_valid=0, flush_target misaligned -> current_pc <= EXC_VEC, misalign_err=1 next cycle only, RAS cleared.
REQ-022 Flush or exception ignores call/ret in the same cycle; an aligned flush leaves RAS contents unchanged.
REQ-023 stall=1, no flush/exc -> current_pc and RAS hold; call/ret ignored.
REQ-024 Sequential: current_pc <= current_pc + INC, modulo 2^XLEN (wrap to 0, no flag).
REQ-025 ret=1, RAS non-empty -> current_pc <= RAS top; pop (ras_count decrements).
REQ-026 ret=1, RAS empty -> sequential next PC; no pop; ras_count stays 0.
REQ-027 call=1 alone -> push current_pc+INC; current_pc advances sequentially (target supplied later via flush).
REQ-028 Push when full (ras_count=RAS_DEPTH) -> circular overwrite of the oldest entry; ras_count stays RAS_DEPTH.
REQ-029 call=1 and ret=1 together, RAS non-empty -> next PC = old top; top replaced by current_pc+INC; ras_count unchanged.
REQ-030 call=1 and ret=1 together, RAS empty -> sequential next PC; push current_pc+INC.
REQ-031 RAS is a circular buffer with a top pointer that wraps modulo RAS_DEPTH.
REQ-032 Latency: every redirect is visible on current_pc one clock after the input cycle; no combinational input-to-output path.

Reset
REQ-033 rst=1 -> immediately current_pc=RESET_VEC, ras_count=0, misalign_err=0, RAS pointer=0, independent of clk.
REQ-034 Reset asserted mid-operation (pending flush, full RAS) discards all state; first post-reset edge with no inputs gives RESET_VEC+INC.
REQ-035 RAS entry storage is not required to be reset; only count and pointer are.

Verification
REQ-036 Reset, 3 idle clocks -> current_pc 0x0, 0x4, 0x8, 0xC; ras_count=0.
REQ-037 At pc=0x10, call; then flush to 0x200; then ret at 0x200 -> pcs 0x14, 0x200, 0x14; ras_count 1 then 0.
REQ-038 RAS_DEPTH=4, five calls at 0x0,0x4,...,0x10, then five rets -> pops 0x14,0x10,0xC,0x8, then sequential; ras_count 4,4,3,2,1,0,0.
REQ-039 stall=1 with flush_valid=1 to 0x80 -> current_pc=0x80; stall=1 alone -> PC held, call ignored, ras_count unchanged.
REQ-040 exc_valid and flush_valid (0x300) together with ras_count=2 -> current_pc=EXC_VEC, ras_count=0.
REQ-041 flush_target=0x102 -> current_pc=EXC_VEC, misalign_err high one cycle; PC=0xFFFF_FFFC sequential -> 0x0.

Source files
------------

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_if
// Description : Fetch-redirect and PC status bundle for pc_gen. The master
//               side (pipeline control) drives the redirect/call/return
//               requests; the slave side (pc_gen) returns the fetch PC,
//               the misalignment pulse and the return-stack occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(RAS_DEPTH) + 1;

  logic               stall;
  logic               flush_valid;
  logic [XLEN-1:0]    flush_target;
  logic               exc_valid;
  logic               call;
  logic               ret;
  logic [XLEN-1:0]    current_pc;
  logic               misalign_err;
  logic [c_CNT_W-1:0] ras_count;

  modport master (
    output stall, flush_valid, flush_target, exc_valid, call, ret,
    input  current_pc, misalign_err, ras_count
  );

  modport slave (
    input  stall, flush_valid, flush_target, exc_valid, call, ret,
    output current_pc, misalign_err, ras_count
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch program-counter generator. Selects the next PC from
//               exception entry, EX-stage redirect, stall hold, return-stack
//               prediction or sequential increment, and maintains a circular
//               return-address stack fed by call/return hints.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0100),
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
  pc_gen_if.slave    pc_if
);

  localparam int                   c_PTR_W   = $clog2(RAS_DEPTH);
  localparam int                   c_CNT_W   = c_PTR_W + 1;
  localparam int                   c_ALIGN_W = $clog2(INC);
  localparam logic [c_CNT_W-1:0]   c_FULL    = c_CNT_W'(RAS_DEPTH);
  localparam logic [XLEN-1:0]      c_INC     = XLEN'(INC);

  // Architectural state
  logic [XLEN-1:0]    r_pc;
  logic [c_PTR_W-1:0] r_ptr;        // next free slot; top entry is r_ptr-1
  logic [c_CNT_W-1:0] r_count;
  logic               r_misalign;
  logic [XLEN-1:0]    r_ras [RAS_DEPTH];

  // Next-state terms
  logic [XLEN-1:0]    w_seq_pc;
  logic [c_PTR_W-1:0] w_top_idx;
  logic               w_ras_empty;
  logic               w_misaligned;
  logic [XLEN-1:0]    w_next_pc;
  logic [c_PTR_W-1:0] w_next_ptr;
  logic [c_CNT_W-1:0] w_next_count;
  logic               w_next_misalign;
  logic               w_wr_en;
  logic [c_PTR_W-1:0] w_wr_idx;

  assign w_seq_pc     = r_pc + c_INC;
  assign w_top_idx    = r_ptr - c_PTR_W'(1);
  assign w_ras_empty  = (r_count == '0);
  assign w_misaligned = |pc_if.flush_target[c_ALIGN_W-1:0];

  // Next-PC priority mux and return-stack bookkeeping
  always_comb begin
    w_next_pc       = w_seq_pc;
    w_next_ptr      = r_ptr;
    w_next_count    = r_count;
    w_next_misalign = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_idx        = r_ptr;

    if (pc_if.exc_valid) begin
      w_next_pc    = EXC_VEC;
      w_next_ptr   = '0;
      w_next_count = '0;
    end else if (pc_if.flush_valid) begin
      if (w_misaligned) begin
        // A misaligned redirect is turned into a trap; stack is discarded.
        w_next_pc       = EXC_VEC;
        w_next_ptr      = '0;
        w_next_count    = '0;
        w_next_misalign = 1'b1;
      end else begin
        w_next_pc = pc_if.flush_target;
      end
    end else if (pc_if.stall) begin
      w_next_pc = r_pc;
    end else if (pc_if.ret && !w_ras_empty) begin
      w_next_pc = r_ras[w_top_idx];
      if (pc_if.call) begin
        // Return-and-call: consume the top and reuse its slot in place.
        w_wr_en  = 1'b1;
        w_wr_idx = w_top_idx;
      end else begin
        w_next_ptr   = w_top_idx;
        w_next_count = r_count - c_CNT_W'(1);
      end
    end else if (pc_if.call) begin
      // When full, r_ptr already addresses the oldest entry, so the push
      // overwrites it without any extra logic.
      w_wr_en    = 1'b1;
      w_wr_idx   = r_ptr;
      w_next_ptr = r_ptr + c_PTR_W'(1);
      if (r_count != c_FULL) begin
        w_next_count = r_count + c_CNT_W'(1);
      end
    end
  end

  // PC, stack pointer/count and error pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_VEC;
      r_ptr      <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_ptr      <= w_next_ptr;
      r_count    <= w_next_count;
      r_misalign <= w_next_misalign;
    end
  end

  // Return-address storage; contents are only meaningful below r_count
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ras[w_wr_idx] <= w_seq_pc;
    end
  end

  assign pc_if.current_pc   = r_pc;
  assign pc_if.misalign_err = r_misalign;
  assign pc_if.ras_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen: a directed vector table run
//               as one continuous instruction stream, plus a hand-written
//               asynchronous-reset-during-activity sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (32'h0000_0100),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        fv;
    logic [31:0] ft;
    logic        ev;
    logic        ca;
    logic        re;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        mis;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic st, input logic fv, input logic [31:0] ft,
                              input logic ev, input logic ca, input logic re,
                              input logic [31:0] pc, input logic [2:0] cnt,
                              input logic mis);
    vec_t v;
    v.st = st; v.fv = fv; v.ft = ft; v.ev = ev; v.ca = ca; v.re = re;
    v.pc = pc; v.cnt = cnt; v.mis = mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fv, input logic [31:0] ft,
                       input logic ev, input logic ca, input logic re);
    bus.stall        = st;
    bus.flush_valid  = fv;
    bus.flush_target = ft;
    bus.exc_valid    = ev;
    bus.call         = ca;
    bus.ret          = re;
  endtask

  // One rising edge, then settle away from it before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc,
                           input logic [2:0] cnt, input logic mis);
    check({tag, " pc"},  bus.current_pc,           pc);
    check({tag, " cnt"}, 32'(bus.ras_count),       32'(cnt));
    check({tag, " mis"}, 32'(bus.misalign_err),    32'(mis));
  endtask

  initial begin
    //               st fv ft            ev ca re  pc            cnt mis
    // idle run from reset
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_000C, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0010, 0, 0));
    // call at 0x10, jump to 0x200, return
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0014, 1, 0));
    vecs.push_back(mk(0, 1, 32'h200,      0, 0, 0, 32'h0000_0200, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0014, 0, 0));
    // five nested calls from 0x0 overflow a 4-deep stack, then five returns
    vecs.push_back(mk(0, 1, 32'h0,        0, 0, 0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0004, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0008, 2, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_000C, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0010, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0014, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0014, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0010, 2, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_000C, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_000C, 0, 0));
    // flush beats stall; stall blocks call and ret
    vecs.push_back(mk(1, 1, 32'h80,       0, 0, 0, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0084, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h0000_0084, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 1, 32'h0000_0084, 1, 0));
    // call+ret with entry: jump to old top (0x84), top becomes 0x88
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_0084, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0088, 0, 0));
    // call+ret on empty stack: sequential and push
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_008C, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0090, 2, 0));
    // exception beats flush and clears stack
    vecs.push_back(mk(0, 1, 32'h300,      1, 0, 0, 32'h0000_0100, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0104, 0, 0));
    // aligned flush ignores call/ret and keeps stack
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_0108, 1, 0));
    vecs.push_back(mk(0, 1, 32'h400,      0, 1, 1, 32'h0000_0400, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0108, 0, 0));
    // misaligned flush: trap, one-cycle error pulse, stack cleared
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h0000_010C, 1, 0));
    vecs.push_back(mk(0, 1, 32'h102,      0, 0, 0, 32'h0000_0100, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0104, 0, 0));
    // exception with misaligned flush: no error pulse
    vecs.push_back(mk(0, 1, 32'h102,      1, 0, 0, 32'h0000_0100, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0104, 0, 0));
    // wrap-around at top of address space
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0000_0004, 0, 0));
    // bit-0 misalignment, and exception under stall
    vecs.push_back(mk(0, 1, 32'h101,      0, 0, 0, 32'h0000_0100, 0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 32'h0000_0100, 0, 0));

    drive(0, 0, 32'h0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check_all("reset-async", 32'h0, 3'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset-held", 32'h0, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].fv, vecs[i].ft, vecs[i].ev, vecs[i].ca, vecs[i].re);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].mis);
    end

    // Fill the stack, leave a redirect pending, then reset asynchronously
    drive(0, 1, 32'h40, 0, 0, 0);
    step();
    check("fill flush pc", bus.current_pc, 32'h40);
    drive(0, 0, 32'h0, 0, 1, 0);
    for (int k = 0; k < 5; k++) step();
    check("fill pc", bus.current_pc, 32'h54);
    check("fill cnt", 32'(bus.ras_count), 32'd4);
    drive(0, 1, 32'h500, 0, 1, 0);
    rst = 1'b1;
    #1;
    check_all("midrst-async", 32'h0, 3'd0, 1'b0);
    step();
    check_all("midrst-edge", 32'h0, 3'd0, 1'b0);
    drive(0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    step();
    check_all("postrst-seq", 32'h4, 3'd0, 1'b0);
    drive(0, 0, 32'h0, 0, 0, 1);
    step();
    check_all("postrst-ret", 32'h8, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
